// File: rtl/mdio_pkg.sv
// Shared constants, FSM state type and frame helpers for the Clause 22 MDIO management station.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_GAP  = 3'd5
    } mdio_state_e;

    // Everything after the preamble, MSB first; the TA/DATA half only matters for writes.
    function automatic logic [31:0] mdio_tx_word(input logic       write,
                                                 input logic [4:0] phyad,
                                                 input logic [4:0] regad,
                                                 input logic [15:0] wdata);
        return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad, 2'b10,
                (write ? wdata : 16'h0000)};
    endfunction

    function automatic mdio_state_e mdio_state_after(input mdio_state_e st);
        case (st)
            ST_PRE:  return ST_HDR;
            ST_HDR:  return ST_TA;
            ST_TA:   return ST_DATA;
            ST_DATA: return ST_GAP;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Command/response bundle between local control logic and mdio_master.
// cmd_no_pre exists only when MDIO_PRE_SUPPRESS_EN is defined.
interface mdio_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
`ifdef MDIO_PRE_SUPPRESS_EN
    logic        cmd_no_pre;
`endif
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    // master: the mdio_master side; slave: the requesting control logic.
    modport master (
`ifdef MDIO_PRE_SUPPRESS_EN
        input  cmd_no_pre,
`endif
        input  cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
`ifdef MDIO_PRE_SUPPRESS_EN
        output cmd_no_pre,
`endif
        output cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/mdio_clk_gen.sv
// MDC divider: one MDIO bit per CLK_DIV clk cycles, mdc low for the first half, high for the second.
module mdio_clk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic mdc,
    output logic bit_start,
    output logic sample
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdc       = en & (cnt_q >= HALF);
    assign sample    = en & (cnt_q == HALF);
    // Last cycle of a bit: the edge that ends it opens the next bit.
    assign bit_start = en & (cnt_q == LAST);

endmodule

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO management station: serialises read/write frames onto MDC/MDIO.
// Optional MDIO_PRE_SUPPRESS_EN adds cmd_no_pre to skip the preamble per command.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int PRE_LEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    mdio_master_if.master cmd,
    output logic          mdc,
    output logic          mdio_o,
    input  logic          mdio_i,
    output logic          mdio_t
);

    generate
        if ((CLK_DIV < 4) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
            $error("mdio_master: CLK_DIV must be even and >= 4");
        end
        if ((PRE_LEN < 1) || (PRE_LEN > 64)) begin : g_bad_pre
            $error("mdio_master: PRE_LEN must be in 1..64");
        end
    endgenerate

    localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
    localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
    localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

    mdio_state_e state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  bit_last;

    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic        ta_err_q, ta_err_d;
    logic        write_q, write_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic accept;
    logic busy;
    logic skip_pre;
    logic mdc_raw;
    logic bit_start;
    logic sample;

    assign busy   = (state_q != ST_IDLE);
    assign accept = cmd.cmd_valid & ~busy;

`ifdef MDIO_PRE_SUPPRESS_EN
    assign skip_pre = cmd.cmd_no_pre;
`else
    assign skip_pre = 1'b0;
`endif

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (accept),
        .en        (busy),
        .mdc       (mdc_raw),
        .bit_start (bit_start),
        .sample    (sample)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // One bit counter is shared by every state; it restarts at zero on each state change.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_last  = '0;
        case (state_q)
            ST_PRE:  bit_last = PRE_LAST;
            ST_HDR:  bit_last = HDR_LAST;
            ST_TA:   bit_last = TA_LAST;
            ST_DATA: bit_last = DATA_LAST;
            default: bit_last = '0;
        endcase
        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d   = skip_pre ? ST_HDR : ST_PRE;
                bit_cnt_d = '0;
            end
        end else if (bit_start) begin
            if (bit_cnt_q == bit_last) begin
                state_d   = mdio_state_after(state_q);
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end
        end
    end

    always_comb begin
        mdio_o = 1'b1;
        mdio_t = 1'b1;
        case (state_q)
            ST_PRE: begin
                mdio_t = 1'b0;
            end
            ST_HDR: begin
                mdio_t = 1'b0;
                mdio_o = tx_q[31];
            end
            ST_TA, ST_DATA: begin
                if (write_q) begin
                    mdio_t = 1'b0;
                    mdio_o = tx_q[31];
                end
            end
            default: ;
        endcase
    end

    assign mdc = mdc_raw & (state_q != ST_GAP);

    always_comb begin
        tx_d        = tx_q;
        rx_d        = rx_q;
        ta_err_d    = ta_err_q;
        write_d     = write_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            tx_d     = mdio_tx_word(cmd.cmd_write, cmd.cmd_phyad, cmd.cmd_regad, cmd.cmd_wdata);
            write_d  = cmd.cmd_write;
            ta_err_d = 1'b0;
        end else if (bit_start && ((state_q == ST_HDR) || (state_q == ST_TA) ||
                                   (state_q == ST_DATA))) begin
            tx_d = {tx_q[30:0], 1'b0};
        end
        // A responder pulls the second TA bit low; a floating (pulled-up) line means nobody answered.
        if (sample && (state_q == ST_TA) && (bit_cnt_q == TA_LAST)) begin
            ta_err_d = mdio_i;
        end
        if (sample && (state_q == ST_DATA)) begin
            rx_d = {rx_q[14:0], mdio_i};
        end
        if (bit_start && (state_q == ST_GAP)) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = write_q ? 16'h0000 : rx_q;
            rsp_err_d   = write_q ? 1'b0 : ta_err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q        <= '0;
            rx_q        <= '0;
            ta_err_q    <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ta_err_q    <= ta_err_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd.cmd_ready = ~busy;
    assign cmd.busy      = busy;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_rdata = rsp_rdata_q;
    assign cmd.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master (CLK_DIV=4, PRE_LEN=32) with a Clause 22 responder at PHYAD 7.
module tb_mdio_master;

    localparam int CLK_DIV = 4;
    localparam int PRE_LEN = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mdc, mdio_o, mdio_i, mdio_t;

    int n_cmp = 0;
    int n_fail = 0;

    mdio_master_if ifc ();

    mdio_master #(
        .CLK_DIV (CLK_DIV),
        .PRE_LEN (PRE_LEN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd     (ifc),
        .mdc     (mdc),
        .mdio_o  (mdio_o),
        .mdio_i  (mdio_i),
        .mdio_t  (mdio_t)
    );

    always #5 clk = ~clk;

    // Responder model: captures the frame on MDC rising, drives TA/data on MDC falling.
    logic        model_clr = 1'b0;
    logic        resp_en = 1'b0;
    logic        resp_val = 1'b1;
    logic        m_started = 1'b0;
    int          m_k = 0;
    int          m_ones = 0;
    int          m_pre = 0;
    logic [13:0] m_hdr = '0;
    logic [1:0]  m_ta = '0;
    logic [15:0] m_data = '0;
    logic [15:0] m_rword;
    int          cont_cnt = 0;

    function automatic logic [15:0] reg_val(input logic [4:0] r);
        case (r)
            5'd1:    return 16'h01A8;
            5'd2:    return 16'h7949;
            default: return {11'h000, r};
        endcase
    endfunction

    assign m_rword = reg_val(m_hdr[4:0]);
    assign mdio_i  = !mdio_t ? mdio_o : (resp_en ? resp_val : 1'b1);

    always @(posedge mdc or posedge model_clr) begin
        if (model_clr) begin
            m_started <= 1'b0;
            m_k       <= 0;
            m_ones    <= 0;
        end else if (!m_started) begin
            if (mdio_i) begin
                m_ones <= m_ones + 1;
            end else begin
                m_started <= 1'b1;
                m_pre     <= m_ones;
                m_ones    <= 0;
                m_hdr     <= '0;
                m_k       <= 1;
            end
        end else begin
            if (m_k < 14) m_hdr <= {m_hdr[12:0], mdio_i};
            else if (m_k < 16) m_ta <= {m_ta[0], mdio_i};
            else m_data <= {m_data[14:0], mdio_i};
            if (m_k == 31) m_started <= 1'b0;
            m_k <= m_k + 1;
        end
    end

    always @(negedge mdc or posedge model_clr) begin
        if (model_clr) begin
            resp_en  <= 1'b0;
            resp_val <= 1'b1;
        end else if (m_started && (m_hdr[11:10] == 2'b10) && (m_hdr[9:5] == 5'd7) && (m_k >= 15)) begin
            resp_en  <= 1'b1;
            resp_val <= (m_k == 15) ? 1'b0 : m_rword[4'(31 - m_k)];
        end else begin
            resp_en  <= 1'b0;
            resp_val <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!mdio_t && resp_en) cont_cnt <= cont_cnt + 1;
    end

    // Issues one command and follows it to rsp_valid, checking mdc and mdio_t shape per cycle.
    task automatic run_cmd(input logic wr, input logic [4:0] phy, input logic [4:0] rad,
                           input logic [15:0] wd, input logic nopre,
                           output int lat, output int t_bad, output int mdc_bad, output int rdy_bad);
        int pre;
        int b;
        int ph;
        logic exp_mdc;
        logic exp_t;
        pre = nopre ? 0 : PRE_LEN;
        lat = 0; t_bad = 0; mdc_bad = 0; rdy_bad = 0;
        @(negedge clk);
        ifc.cmd_write = wr;
        ifc.cmd_phyad = phy;
        ifc.cmd_regad = rad;
        ifc.cmd_wdata = wd;
`ifdef MDIO_PRE_SUPPRESS_EN
        ifc.cmd_no_pre = nopre;
`endif
        ifc.cmd_valid = 1'b1;
        if (ifc.cmd_ready !== 1'b1) rdy_bad++;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ifc.cmd_valid = 1'b0;
                ifc.cmd_wdata = 16'hDEAD;
                ifc.cmd_regad = 5'd31;
            end
            if (ifc.rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
            b = (c - 1) / CLK_DIV;
            ph = (c - 1) % CLK_DIV;
            exp_mdc = (b < pre + 32) && (ph >= CLK_DIV / 2);
            exp_t = (b >= pre + 32) || (!wr && (b >= pre + 14));
            if (mdc !== exp_mdc) mdc_bad++;
            if (mdio_t !== exp_t) t_bad++;
            if (ifc.cmd_ready !== 1'b0) rdy_bad++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        model_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", ifc.cmd_ready); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
        n_cmp++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", ifc.rsp_valid); end
        n_cmp++; if (ifc.rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0000", ifc.rsp_rdata); end
        n_cmp++; if (ifc.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", ifc.rsp_err); end
        n_cmp++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL rst_mdc: got %b want 0", mdc); end
        n_cmp++; if (mdio_o !== 1'b1) begin n_fail++; $display("FAIL rst_mdio_o: got %b want 1", mdio_o); end
        n_cmp++; if (mdio_t !== 1'b1) begin n_fail++; $display("FAIL rst_mdio_t: got %b want 1", mdio_t); end
        model_clr = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int lat, t_bad, mdc_bad, rdy_bad;
        run_cmd(1'b1, 5'b00111, 5'd0, 16'h1140, 1'b0, lat, t_bad, mdc_bad, rdy_bad);
        n_cmp++; if (lat !== 261) begin n_fail++; $display("FAIL wr_latency: got %0d want 261", lat); end
        n_cmp++; if (ifc.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err: got %b want 0", ifc.rsp_err); end
        n_cmp++; if (ifc.rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rsp_rdata: got %h want 0000", ifc.rsp_rdata); end
        n_cmp++; if (m_pre !== 32) begin n_fail++; $display("FAIL wr_preamble: got %0d want 32", m_pre); end
        n_cmp++; if (m_hdr !== 14'b01_01_00111_00000) begin n_fail++; $display("FAIL wr_header: got %b want 01010011100000", m_hdr); end
        n_cmp++; if (m_ta !== 2'b10) begin n_fail++; $display("FAIL wr_ta: got %b want 10", m_ta); end
        n_cmp++; if (m_data !== 16'h1140) begin n_fail++; $display("FAIL wr_data: got %h want 1140", m_data); end
        n_cmp++; if (t_bad !== 0) begin n_fail++; $display("FAIL wr_mdio_t: got %0d bad cycles want 0", t_bad); end
        n_cmp++; if (mdc_bad !== 0) begin n_fail++; $display("FAIL wr_mdc: got %0d bad cycles want 0", mdc_bad); end
        n_cmp++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL wr_cmd_ready: got %0d bad cycles want 0", rdy_bad); end
        @(negedge clk);
        n_cmp++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b want 0", ifc.rsp_valid); end
    endtask

    task automatic test_read;
        int lat, t_bad, mdc_bad, rdy_bad;
        run_cmd(1'b0, 5'd7, 5'd1, 16'hFFFF, 1'b0, lat, t_bad, mdc_bad, rdy_bad);
        n_cmp++; if (lat !== 261) begin n_fail++; $display("FAIL rd_latency: got %0d want 261", lat); end
        n_cmp++; if (ifc.rsp_rdata !== 16'h01A8) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h want 01a8", ifc.rsp_rdata); end
        n_cmp++; if (ifc.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_err: got %b want 0", ifc.rsp_err); end
        n_cmp++; if (m_hdr !== 14'b01_10_00111_00001) begin n_fail++; $display("FAIL rd_header: got %b want 01100011100001", m_hdr); end
        n_cmp++; if (t_bad !== 0) begin n_fail++; $display("FAIL rd_mdio_t: got %0d bad cycles want 0", t_bad); end
        n_cmp++; if (mdc_bad !== 0) begin n_fail++; $display("FAIL rd_mdc: got %0d bad cycles want 0", mdc_bad); end
    endtask

    task automatic test_read_no_responder;
        int lat, t_bad, mdc_bad, rdy_bad;
        run_cmd(1'b0, 5'd3, 5'd1, 16'h0000, 1'b0, lat, t_bad, mdc_bad, rdy_bad);
        n_cmp++; if (lat !== 261) begin n_fail++; $display("FAIL nr_latency: got %0d want 261", lat); end
        n_cmp++; if (ifc.rsp_err !== 1'b1) begin n_fail++; $display("FAIL nr_rsp_err: got %b want 1", ifc.rsp_err); end
        n_cmp++; if (ifc.rsp_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL nr_rsp_rdata: got %h want ffff", ifc.rsp_rdata); end
        repeat (5) @(negedge clk);
        n_cmp++; if (ifc.rsp_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL nr_rdata_hold: got %h want ffff", ifc.rsp_rdata); end
        n_cmp++; if (ifc.rsp_err !== 1'b1) begin n_fail++; $display("FAIL nr_err_hold: got %b want 1", ifc.rsp_err); end
    endtask

    task automatic test_reset_mid_frame;
        int rsp_seen;
        int mdc_seen;
        int rdy_low;
        rsp_seen = 0; mdc_seen = 0; rdy_low = 0;
        @(negedge clk);
        ifc.cmd_write = 1'b1;
        ifc.cmd_phyad = 5'd7;
        ifc.cmd_regad = 5'd4;
        ifc.cmd_wdata = 16'hA5A5;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 163; c++) begin
            @(negedge clk);
            if (c == 1) ifc.cmd_valid = 1'b0;
        end
        n_cmp++; if (mdc !== 1'b1) begin n_fail++; $display("FAIL mid_mdc_before: got %b want 1", mdc); end
        #1;
        reset_n = 1'b0;
        model_clr = 1'b1;
        #1;
        n_cmp++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL mid_mdc: got %b want 0", mdc); end
        n_cmp++; if (mdio_t !== 1'b1) begin n_fail++; $display("FAIL mid_mdio_t: got %b want 1", mdio_t); end
        n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready: got %b want 1", ifc.cmd_ready); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", ifc.busy); end
        repeat (2) @(posedge clk);
        model_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ifc.rsp_valid !== 1'b0) rsp_seen++;
            if (mdc !== 1'b0) mdc_seen++;
            if (ifc.cmd_ready !== 1'b1) rdy_low++;
        end
        n_cmp++; if (rsp_seen !== 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d pulses want 0", rsp_seen); end
        n_cmp++; if (mdc_seen !== 0) begin n_fail++; $display("FAIL mid_idle_mdc: got %0d high cycles want 0", mdc_seen); end
        n_cmp++; if (rdy_low !== 0) begin n_fail++; $display("FAIL mid_idle_ready: got %0d low cycles want 0", rdy_low); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, rdy_hi;
        logic rdy_at_rsp;
        logic [15:0] rdata1;
        lat1 = 0; lat2 = 0; rdy_hi = 0;
        rdy_at_rsp = 1'b0;
        rdata1 = '0;
        @(negedge clk);
        ifc.cmd_write = 1'b0;
        ifc.cmd_phyad = 5'd7;
        ifc.cmd_regad = 5'd1;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) ifc.cmd_regad = 5'd2;
            if (ifc.rsp_valid === 1'b1) begin
                lat1 = c;
                rdy_at_rsp = ifc.cmd_ready;
                rdata1 = ifc.rsp_rdata;
                break;
            end
        end
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) ifc.cmd_valid = 1'b0;
            if (ifc.rsp_valid === 1'b1) begin
                lat2 = c;
                break;
            end
            if (ifc.cmd_ready !== 1'b0) rdy_hi++;
        end
        n_cmp++; if (lat1 !== 261) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 261", lat1); end
        n_cmp++; if (rdy_at_rsp !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_rsp: got %b want 1", rdy_at_rsp); end
        n_cmp++; if (rdata1 !== 16'h01A8) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 01a8", rdata1); end
        n_cmp++; if (lat2 !== 261) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 261", lat2); end
        n_cmp++; if (ifc.rsp_rdata !== 16'h7949) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 7949", ifc.rsp_rdata); end
        n_cmp++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL b2b_ready_frame2: got %0d high cycles want 0", rdy_hi); end
    endtask

`ifdef MDIO_PRE_SUPPRESS_EN
    task automatic test_no_pre;
        int lat, t_bad, mdc_bad, rdy_bad;
        run_cmd(1'b0, 5'd7, 5'd2, 16'h0000, 1'b1, lat, t_bad, mdc_bad, rdy_bad);
        n_cmp++; if (lat !== 133) begin n_fail++; $display("FAIL np_latency: got %0d want 133", lat); end
        n_cmp++; if (ifc.rsp_rdata !== 16'h7949) begin n_fail++; $display("FAIL np_rdata: got %h want 7949", ifc.rsp_rdata); end
        n_cmp++; if (m_pre !== 0) begin n_fail++; $display("FAIL np_preamble: got %0d want 0", m_pre); end
        n_cmp++; if (t_bad !== 0) begin n_fail++; $display("FAIL np_mdio_t: got %0d bad cycles want 0", t_bad); end
        n_cmp++; if (mdc_bad !== 0) begin n_fail++; $display("FAIL np_mdc: got %0d bad cycles want 0", mdc_bad); end
    endtask
`endif

    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_phyad = '0;
        ifc.cmd_regad = '0;
        ifc.cmd_wdata = '0;
`ifdef MDIO_PRE_SUPPRESS_EN
        ifc.cmd_no_pre = 1'b0;
`endif
        test_reset();
        test_write();
        test_read();
        test_read_no_responder();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef MDIO_PRE_SUPPRESS_EN
        test_no_pre();
`endif
        n_cmp++; if (cont_cnt !== 0) begin n_fail++; $display("FAIL bus_contention: got %0d cycles want 0", cont_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
